// File: rtl/dot_pkg.sv
// Shared constants, framing field positions and feeder state type for the
// 10-element dot-product pipeline and its feeder.
package dot_pkg;

    localparam int unsigned N_ELEM     = 10;
    localparam int unsigned OP_W       = 32;
    localparam int unsigned DP_OUT_W   = 53;
    localparam int unsigned DP_LATENCY = 6;

    localparam int unsigned FLAG_HI = 52;
    localparam int unsigned FLAG_LO = 33;
    localparam int unsigned SUM_HI  = 32;
    localparam int unsigned SUM_LO  = 1;

    typedef enum logic {
        FILL,
        ISSUE
    } feed_state_t;

endpackage

// File: rtl/dot_10_feeder_if.sv
// Operand-in and result-out valid/ready streams of the dot-product feeder.
// master = upstream/consumer side, slave = feeder side.
interface dot_10_feeder_if #(
    parameter int unsigned OP_W = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_a;
    logic [OP_W-1:0] in_b;

    logic            res_valid;
    logic            res_ready;
    logic [OP_W-1:0] res_data;
    logic            res_err;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/dot_10_feeder_res_fifo.sv
// Small circular result FIFO with valid/ready output and an occupancy count.
// Push and pop may coincide at any occupancy.
module dot_res_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The feeder's credit rule keeps a push away from a full FIFO unless it pops too.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/dot_10_feeder.sv
// Serial-to-parallel operand feeder for the 10-element dot-product pipeline:
// assembles A/B pairs, issues them with result credit, tags and captures results.
module dot_10_feeder #(
    parameter int unsigned N_ELEM     = dot_pkg::N_ELEM,
    parameter int unsigned OP_W       = dot_pkg::OP_W,
    parameter int unsigned DP_LATENCY = dot_pkg::DP_LATENCY,
    parameter int unsigned RES_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    dot_10_feeder_if.slave                io,
    output logic [N_ELEM*OP_W-1:0]        dp_a,
    output logic [N_ELEM*OP_W-1:0]        dp_b,
    input  logic [dot_pkg::DP_OUT_W-1:0]  dp_out,
    output logic                          busy
);

    import dot_pkg::*;

    localparam int unsigned CNT_W  = $clog2(N_ELEM);
    localparam int unsigned INF_W  = $clog2(DP_LATENCY+1);
    localparam int unsigned FCNT_W = $clog2(RES_DEPTH+1);

    feed_state_t        state;
    feed_state_t        state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DP_LATENCY-1:0] dl;
    logic [INF_W-1:0]   inflight;
    logic [FCNT_W-1:0]  fifo_cnt;
    logic               fill_xfer;
    logic               cnt_last;
    logic               credit_ok;
    logic               issue;
    logic [OP_W-1:0]    cap_data;
    logic               cap_err;
    logic [OP_W:0]      fifo_out;

    assign cnt_last  = (cnt == CNT_W'(N_ELEM-1));
    assign fill_xfer = io.in_valid && (state == FILL);
    assign inflight  = INF_W'($countones(dl));
    // Credit counts in-flight tags as well as buffered results so a tagged result always has a slot.
    assign credit_ok = (32'(fifo_cnt) + 32'(inflight)) < RES_DEPTH;

    always_comb begin
        state_nxt   = state;
        io.in_ready = 1'b0;
        issue       = 1'b0;
        case (state)
            FILL: begin
                io.in_ready = 1'b1;
                if (io.in_valid && cnt_last) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue     = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dp_a <= '0;
            dp_b <= '0;
        end else if (fill_xfer) begin
            dp_a[32'(cnt)*OP_W +: OP_W] <= io.in_a;
            dp_b[32'(cnt)*OP_W +: OP_W] <= io.in_b;
            cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl <= '0;
        end else begin
            dl <= {dl[DP_LATENCY-2:0], issue};
        end
    end

    assign cap_data = dp_out[SUM_HI:SUM_LO];
    assign cap_err  = !((&dp_out[FLAG_HI:FLAG_LO]) && dp_out[0]);

    dot_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (OP_W+1)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dl[DP_LATENCY-1]),
        .push_data ({cap_err, cap_data}),
        .out_valid (io.res_valid),
        .out_ready (io.res_ready),
        .out_data  (fifo_out),
        .count     (fifo_cnt)
    );

    assign io.res_data = fifo_out[OP_W-1:0];
    assign io.res_err  = fifo_out[OP_W];

    assign busy = (cnt != '0) || (state == ISSUE) || (inflight != '0) || (fifo_cnt != '0);

endmodule

// File: tb/tb_dot_10_feeder.sv
// Scoreboard bench for dot_10_feeder with a latency-6 behavioural pipeline
// model standing in for dot_10_pipeline.
module tb_dot_10_feeder;

    localparam int unsigned NE = 10;
    localparam int unsigned W  = 32;
    localparam logic [31:0] MAGIC = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NE*W-1:0] dp_a;
    logic [NE*W-1:0] dp_b;
    logic [52:0]     dp_out;
    logic            busy;

    always #5 clk = ~clk;

    dot_10_feeder_if #(.OP_W(W)) io ();

    dot_10_feeder #(
        .N_ELEM     (NE),
        .OP_W       (W),
        .DP_LATENCY (6),
        .RES_DEPTH  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io     (io),
        .dp_a   (dp_a),
        .dp_b   (dp_b),
        .dp_out (dp_out),
        .busy   (busy)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc      = 0;
    exp_t        exp_q[$];
    bit          stress_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Pipeline model: result of the operands present in cycle t appears on dp_out in cycle t+6.
    // A vector whose element A0 is MAGIC comes back with a broken framing bit 0.
    function automatic logic [31:0] pipe_sum(input logic [NE*W-1:0] a, input logic [NE*W-1:0] b);
        logic [31:0] s = '0;
        for (int i = 0; i < NE; i++) s = s + a[i*W +: W] * b[i*W +: W];
        return s;
    endfunction

    logic [52:0] pm [6];
    always @(posedge clk) begin
        pm[0] <= {20'hFFFFF, pipe_sum(dp_a, dp_b), (dp_a[31:0] == MAGIC) ? 1'b0 : 1'b1};
        for (int k = 1; k < 6; k++) pm[k] <= pm[k-1];
    end
    assign dp_out = pm[5];

    // Reference: signed dot product reduced modulo 2^32.
    function automatic exp_t ref_model(input int a[NE], input int b[NE]);
        exp_t   r;
        longint acc = 0;
        for (int i = 0; i < NE; i++) acc += longint'(a[i]) * longint'(b[i]);
        r.data = acc[31:0];
        r.err  = (a[0] == int'(MAGIC));
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && io.res_valid && io.res_ready) begin
            automatic exp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(io.res_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("res_data", 64'(io.res_data), 64'(e.data));
                check("res_err", 64'(io.res_err), 64'(e.err));
            end
        end
    end

    task automatic send_n(input int a[NE], input int b[NE], input int n, input bit push_exp,
                          output int unsigned first_cyc);
        int unsigned t;
        first_cyc = 0;
        if (push_exp) exp_q.push_back(ref_model(a, b));
        for (int i = 0; i < n; i++) begin
            io.in_valid = 1'b1;
            io.in_a     = a[i];
            io.in_b     = b[i];
            t = 0;
            @(negedge clk);
            while (!io.in_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) check("in_ready_timeout", 64'(t), 64'd0);
            if (i == 0) first_cyc = cyc;
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
    endtask

    task automatic send_vec(input int a[NE], input int b[NE]);
        int unsigned fc;
        send_n(a, b, NE, 1'b1, fc);
    endtask

    task automatic rand_vec(output int a[NE], output int b[NE]);
        for (int i = 0; i < NE; i++) begin
            a[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) - 10 : int'($urandom);
            b[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) - 10 : int'($urandom);
        end
        if (a[0] == int'(MAGIC)) a[0] = 0;
    endtask

    task automatic drain(input string name);
        int unsigned t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && t < 400) begin
            t++;
            @(negedge clk);
        end
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a[NE];
        int          b[NE];
        int unsigned fc;
        int unsigned t;

        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.res_ready = 1'b1;
        stress_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(io.in_ready), 64'd1);
        check("rst_res_valid", 64'(io.res_valid), 64'd0);
        check("rst_res_data", 64'(io.res_data), 64'd0);
        check("rst_res_err", 64'(io.res_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dp_nonzero", 64'(|{dp_a, dp_b}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: ascending vectors, first-result latency
        for (int i = 0; i < NE; i++) begin
            a[i] = i + 1;
            b[i] = i + 1;
        end
        send_n(a, b, NE, 1'b1, fc);
        t = 0;
        @(negedge clk);
        while (!io.res_valid && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("t1_latency", 64'(cyc - fc), 64'd17);
        check("t1_value", 64'(io.res_data), 64'd385);
        drain("t1");

        // 2: negative operands
        for (int i = 0; i < NE; i++) begin
            a[i] = -1;
            b[i] = 2;
        end
        send_vec(a, b);
        drain("t2");

        // 3: product wrap
        for (int i = 0; i < NE; i++) begin
            a[i] = 0;
            b[i] = 0;
        end
        a[0] = 32'h7FFFFFFF;
        b[0] = 2;
        send_vec(a, b);
        drain("t3");

        // 4: consumer stalled, third vector blocked on credit
        io.res_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            rand_vec(a, b);
            send_vec(a, b);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t4_in_ready_held", 64'(io.in_ready), 64'd0);
        check("t4_res_valid", 64'(io.res_valid), 64'd1);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_pending", 64'(exp_q.size()), 64'd3);
        @(posedge clk);
        #1;
        io.res_ready = 1'b1;
        drain("t4");

        // 5: reset with a result in flight and a partial vector held
        rand_vec(a, b);
        send_n(a, b, NE, 1'b0, fc);
        rand_vec(a, b);
        send_n(a, b, 4, 1'b0, fc);
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_ready", 64'(io.in_ready), 64'd1);
        check("t5_res_valid", 64'(io.res_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_dp_nonzero", 64'(|{dp_a, dp_b}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rand_vec(a, b);
        send_vec(a, b);
        drain("t5");

        // 6: framing error on one result only
        rand_vec(a, b);
        send_vec(a, b);
        rand_vec(a, b);
        a[0] = int'(MAGIC);
        send_vec(a, b);
        rand_vec(a, b);
        send_vec(a, b);
        drain("t6");

        // 7: random backpressure
        fork
            begin
                for (int v = 0; v < 15; v++) begin
                    rand_vec(a, b);
                    if ($urandom_range(0, 5) == 0) a[0] = int'(MAGIC);
                    send_vec(a, b);
                end
                stress_done = 1'b1;
            end
            begin
                while (!stress_done) begin
                    @(posedge clk);
                    #1;
                    io.res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        io.res_ready = 1'b1;
        drain("t7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
